cordic_iter_engine: RTL

- Iterative 8-bit CORDIC rotation-mode engine.
- Owns the X/Y/Z working registers and the iteration controller, and applies the per-iteration arithmetic right shifts (the shift-by-i stages) to its own registers.
- Sits between the operand loader and the post-gain scaling stage. It rotates vector (x,y) by angle z over ITER iterations and hands the unscaled result downstream with a done pulse.

---
 rtl/cordic_iter_engine.sv | 125 ++++++++++++
 1 files changed

// File: rtl/cordic_iter_engine.sv
// Iterative rotation-mode CORDIC engine.
// Rotates (x_in, y_in) by z_in over ITER iterations, one iteration per clock.
// The result is left unscaled (gain of about 1.647); a later stage compensates.
// z is in binary-angle units: 128 = pi rad, so one LSB = pi/128.
//
// Handshake: start is a request that is sampled only in IDLE or DONE.
// A sampled start captures x_in/y_in/z_in on that same edge.
// busy is high for the whole RUN state, and start is ignored while busy.
// done is high for exactly one cycle, and x_out/y_out/z_out are valid in that cycle.
// The outputs then hold until the next completion.
// Raising start during the done cycle launches the next operation with no idle gap.
// ITER must lie in 1..4: the atan table has only four entries and the counter is 2 bits wide.
module cordic_iter_engine #(
    parameter int WIDTH = 8,
    parameter int ITER  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    input  logic [WIDTH-1:0] z_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out,
    output logic [WIDTH-1:0] z_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] ITER_LAST = 2'(ITER - 1);

    logic [1:0]              state;
    logic [1:0]              iter;
    logic signed [WIDTH-1:0] x_r, y_r, z_r;
    logic signed [WIDTH-1:0] x_sh, y_sh;
    logic signed [WIDTH-1:0] x_nx, y_nx, z_nx;
    logic signed [WIDTH-1:0] atan_val;
    logic                    load;
    logic                    iter_last;

    // Decode the state into status outputs and the load and last-iteration conditions.
    always_comb begin
        busy      = (state == S_RUN);
        done      = (state == S_DONE);
        load      = start && ((state == S_IDLE) || (state == S_DONE));
        iter_last = (iter == ITER_LAST);
    end

    // Look up atan(2^-i) in binary-angle units for the current iteration.
    always_comb begin
        atan_val = '0;
        case (iter)
            2'd0:    atan_val = 8'sd32;
            2'd1:    atan_val = 8'sd19;
            2'd2:    atan_val = 8'sd10;
            2'd3:    atan_val = 8'sd5;
            default: atan_val = '0;
        endcase
    end

    // Compute one CORDIC micro-rotation.
    // The rotation direction comes from the sign of z.
    // All sums wrap modulo 2^WIDTH.
    always_comb begin
        x_sh = x_r >>> iter;
        y_sh = y_r >>> iter;
        if (!z_r[WIDTH-1]) begin
            x_nx = x_r - y_sh;
            y_nx = y_r + x_sh;
            z_nx = z_r - atan_val;
        end else begin
            x_nx = x_r + y_sh;
            y_nx = y_r - x_sh;
            z_nx = z_r + atan_val;
        end
    end

    // Update the controller FSM, the working registers and the result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            iter  <= '0;
            x_r   <= '0;
            y_r   <= '0;
            z_r   <= '0;
            x_out <= '0;
            y_out <= '0;
            z_out <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (load) begin
                        x_r   <= x_in;
                        y_r   <= y_in;
                        z_r   <= z_in;
                        iter  <= '0;
                        state <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    x_r <= x_nx;
                    y_r <= y_nx;
                    z_r <= z_nx;
                    if (iter_last) begin
                        x_out <= x_nx;
                        y_out <= y_nx;
                        z_out <= z_nx;
                        iter  <= '0;
                        state <= S_DONE;
                    end else begin
                        iter <= iter + 2'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
